// File: rtl/seg_to_binary_pkg.sv
// Shared definitions for the 7-segment to binary read-back path:
// segment patterns, FSM states and the reverse double-dabble step.
package seg_to_binary_pkg;

  // Active-high patterns, bit6..bit0 = a,b,c,d,e,f,g
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int unsigned SHIFT_CYCLES = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Register layout {tens[3:0], ones[3:0], bin[6:0]}: shift right, then
  // correct each BCD nibble that landed at 8 or above by subtracting 3.
  function automatic logic [14:0] rdd_step(input logic [14:0] r);
    logic [14:0] s;
    s = {1'b0, r[14:1]};
    if (s[14:11] >= 4'd8) s[14:11] = s[14:11] - 4'd3;
    if (s[10:7]  >= 4'd8) s[10:7]  = s[10:7]  - 4'd3;
    return s;
  endfunction

endpackage

// File: rtl/seg_to_binary_decode.sv
// Combinational 7-segment pattern to BCD digit decoder; a blank pattern
// is accepted as zero only when i_blank_ok is set.
module seg_digit_decode
  import seg_to_binary_pkg::*;
(
  input  logic [6:0] i_seg,
  input  logic       i_blank_ok,
  output logic [3:0] o_bcd,
  output logic       o_valid
);

  always_comb begin
    o_bcd   = '0;
    o_valid = 1'b1;
    case (i_seg)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: o_valid = i_blank_ok;
      default:   o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_to_binary.sv
// Two 7-segment digits (tens, ones) to 8-bit binary 0..99 via a
// sequential reverse double-dabble engine with start/busy/done handshake.
module seg_to_binary
  import seg_to_binary_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter int unsigned SHIFT_CYCLES   = seg_to_binary_pkg::SHIFT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] seg_l,
  input  logic [6:0] seg_r,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] binary
);

  localparam int unsigned     CNT_W = $clog2(SHIFT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SHIFT_CYCLES - 1);

  logic [6:0]  w_seg_l;
  logic [6:0]  w_seg_r;
  logic [3:0]  w_tens;
  logic [3:0]  w_ones;
  logic        w_tens_ok;
  logic        w_ones_ok;
  logic [14:0] w_step;

  state_t           r_state;
  logic [14:0]      r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [7:0]       r_binary;

  assign w_seg_l = SEG_ACTIVE_LOW ? ~seg_l : seg_l;
  assign w_seg_r = SEG_ACTIVE_LOW ? ~seg_r : seg_r;

  seg_digit_decode u_dec_tens (
    .i_seg      (w_seg_l),
    .i_blank_ok (1'b1),
    .o_bcd      (w_tens),
    .o_valid    (w_tens_ok)
  );

  seg_digit_decode u_dec_ones (
    .i_seg      (w_seg_r),
    .i_blank_ok (1'b0),
    .o_bcd      (w_ones),
    .o_valid    (w_ones_ok)
  );

  assign w_step = rdd_step(r_sr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_binary <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_tens_ok && w_ones_ok) begin
              r_sr    <= {w_tens, w_ones, 7'd0};
              r_cnt   <= '0;
              r_error <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end else begin
              r_error  <= 1'b1;
              r_binary <= '0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        SHIFT: begin
          r_sr  <= w_step;
          r_cnt <= r_cnt + 1'b1;
          // The final shift's result is taken straight from the step logic
          if (r_cnt == LAST) begin
            r_binary <= {1'b0, w_step[6:0]};
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign error  = r_error;
  assign binary = r_binary;

endmodule

// File: tb/tb_seg_to_binary.sv
// Directed bench for seg_to_binary: an active-high instance and an
// active-low instance fed the inverted patterns, checked side by side.
module tb_seg_to_binary;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] seg_l = '0, seg_r = '0, seg_l_n = '1, seg_r_n = '1;
  logic       busy, done, error;
  logic [7:0] binary;
  logic       busy_n, done_n, error_n;
  logic [7:0] binary_n;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  seg_to_binary #(.SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seg_l(seg_l), .seg_r(seg_r),
    .busy(busy), .done(done), .error(error), .binary(binary)
  );

  seg_to_binary #(.SEG_ACTIVE_LOW(1'b1)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .seg_l(seg_l_n), .seg_r(seg_r_n),
    .busy(busy_n), .done(done_n), .error(error_n), .binary(binary_n)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_segs(input logic [6:0] l, input logic [6:0] r);
    seg_l = l; seg_r = r; seg_l_n = ~l; seg_r_n = ~r;
  endtask

  // Called at a negedge with both instances idle; returns at a negedge, idle again.
  task automatic convert(input string tag, input logic [6:0] l, input logic [6:0] r,
                         input logic [7:0] exp_bin, input logic exp_err);
    int lat, bcnt;
    drive_segs(l, r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 16'(lat), exp_err ? 16'd1 : 16'd8);
    check({tag, " busy cycles"}, 16'(bcnt), exp_err ? 16'd0 : 16'd7);
    check({tag, " binary"}, 16'(binary), 16'(exp_bin));
    check({tag, " error"}, 16'(error), 16'(exp_err));
    check({tag, " al done"}, 16'(done_n), 16'd1);
    check({tag, " al binary"}, 16'(binary_n), 16'(exp_bin));
    check({tag, " al error"}, 16'(error_n), 16'(exp_err));
    @(negedge clk);
    check({tag, " done pulse width"}, 16'({done, done_n}), 16'd0);
    check({tag, " binary hold"}, 16'(binary), 16'(exp_bin));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int last, ndone;
    logic [7:0] cap;

    // Reset held with start high and segment inputs toggling
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_segs((k % 2) ? 7'h33 : 7'h7B, (k % 2) ? 7'h6D : 7'h7E);
      @(negedge clk);
      check("reset outputs", {5'd0, busy, done, error, binary}, 16'd0);
      check("reset outputs al", {5'd0, busy_n, done_n, error_n, binary_n}, 16'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset idle", {5'd0, busy, done, error, binary}, 16'd0);

    convert("42", 7'h33, 7'h6D, 8'h2A, 1'b0);
    convert("99", 7'h7B, 7'h7B, 8'h63, 1'b0);
    convert("00", 7'h7E, 7'h7E, 8'h00, 1'b0);
    convert("blank1", 7'h00, 7'h30, 8'h01, 1'b0);
    convert("86", 7'h7F, 7'h5F, 8'h56, 1'b0);
    convert("blank ones", 7'h30, 7'h00, 8'h00, 1'b1);
    convert("57", 7'h5B, 7'h70, 8'h39, 1'b0);
    convert("bad tens", 7'h12, 7'h30, 8'h00, 1'b1);
    convert("both blank", 7'h00, 7'h00, 8'h00, 1'b1);
    convert("73", 7'h70, 7'h79, 8'h49, 1'b0);

    // start re-asserted mid-conversion with changed inputs is ignored
    drive_segs(7'h33, 7'h6D);
    start = 1'b1;
    ndone = 0; cap = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin ndone++; cap = binary; end
      start = (k == 2 || k == 5);
      if (k == 2) drive_segs(7'h7B, 7'h7B);
    end
    check("retrigger done count", 16'(ndone), 16'd1);
    check("retrigger binary", 16'(cap), 16'h2A);

    // start held high: one conversion every 9 cycles
    drive_segs(7'h33, 7'h6D);
    start = 1'b1;
    last = -1; ndone = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) check("back-to-back period", 16'(k - last), 16'd9);
        else check("back-to-back first", 16'(k), 16'd8);
        last = k;
        ndone++;
      end
    end
    check("back-to-back count", 16'(ndone), 16'd3);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during SHIFT after a non-zero result
    convert("99 pre-reset", 7'h7B, 7'h7B, 8'h63, 1'b0);
    drive_segs(7'h33, 7'h6D);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy before reset", 16'(busy), 16'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset outputs", {5'd0, busy, done, error, binary}, 16'd0);
    check("mid reset outputs al", {5'd0, busy_n, done_n, error_n, binary_n}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("no activity after mid reset", 16'(ndone), 16'd0);
    convert("42 after reset", 7'h33, 7'h6D, 8'h2A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_to_binary.md
Name: seg_to_binary

Overview:
- Inverse path of the decimal display chain: accepts two 7-segment patterns (tens, ones) and returns the 8-bit binary value 0..99.
- Used to read back or loop-check display contents, or to accept segment-coded input from a panel.
- Each pattern is decoded to a BCD digit combinationally.
- The binary value is then produced by a sequential reverse double-dabble (shift-right, subtract-3) engine with a start/busy/done handshake.

Parameters:
- SEG_ACTIVE_LOW, 0, when 1 both segment inputs are inverted before decoding.
- SHIFT_CYCLES, 7, number of shift iterations. Fixed at 7, which covers results up to 99; not intended to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- seg_l  input  7  tens pattern, bit6..bit0 = a,b,c,d,e,f,g; 1 = lit when SEG_ACTIVE_LOW=0.
- seg_r  input  7  ones pattern, same bit order.
- busy  output  1  high while a conversion is in SHIFT.
- done  output  1  single-cycle completion pulse.
- error  output  1  last request contained an unrecognised pattern; held until the next accepted start.
- binary  output  8  result; held until the next accepted start.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE; busy=0, done=0, error=0, binary=8'h00, shift register and counter cleared.
- Segment patterns (active-high):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - seg_l=00 (blank) is accepted as tens=0, for leading-zero suppression.
  - seg_r=00 is invalid.
  - Any other pattern is invalid.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, both digits valid, at edge E0:
  - Load the 15-bit register {tens[3:0], ones[3:0], bin[6:0]=0} and clear the counter.
  - error<=0. Go to SHIFT; busy=1 from E0.
- IDLE, start=1, any digit invalid, at edge E0:
  - Go to DONE with error<=1, binary<=0, done<=1, busy stays 0.
- SHIFT, each edge:
  - Shift the whole register right by 1.
  - Then, for each BCD nibble independently: if the nibble is >= 8, subtract 3.
  - Increment the counter.
- SHIFT, on the edge where the counter reaches SHIFT_CYCLES (E7):
  - binary <= {1'b0, bin[6:0]}, done<=1, busy<=0; go to DONE.
- DONE: next edge clears done and returns to IDLE.
- Latency: done is high in the cycle following E7 (7 cycles after start is sampled); on the invalid path, in the cycle following E0.
- start while in SHIFT or DONE is ignored; it is not queued.
- Segment inputs are sampled only at E0; later changes have no effect on the running conversion.
- Reset asserted mid-conversion: immediate return to IDLE; no done pulse; binary is forced to 0.
- start held high continuously: one conversion every 9 cycles (E0, 7 shifts, DONE, then back in IDLE).
- Width: the result never exceeds 99 (7 bits); binary[7] is always 0.

Decomposition:
- Shared package:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - SHIFT_CYCLES.
- One sub-module, seg_digit_decode: 7-bit pattern plus a blank_ok flag in; 4-bit BCD plus valid out; purely combinational.
  - Instantiated twice: tens with blank_ok=1, ones with blank_ok=0.
  - SEG_ACTIVE_LOW inversion happens before these instances.

Test Plan:
- Reset: rst_n low with start=1 and seg inputs toggling -> busy=0, done=0, error=0, binary=00 throughout; first conversion after release behaves normally.
- "42": seg_l=33, seg_r=6D, start pulse -> busy for 7 cycles, then done for 1 cycle with binary=2A, error=0; binary holds 2A after done falls.
- Extremes: "99" (7B,7B) -> binary=63; "00" (7E,7E) -> binary=00; blank tens with "1" (00,30) -> binary=01, error=0.
- Invalid: seg_r=00 -> done in the cycle after start, error=1, binary=00, busy never high. Then a valid "57" (5B,70) -> error cleared, binary=39.
- Handshake: start re-asserted at cycles 2 and 5 of "42", with seg inputs changed to "99" -> result is still 2A, exactly one done pulse. Back-to-back start held high -> done every 9 cycles.
- Reset mid-SHIFT at cycle 4 -> state IDLE, busy=0, binary=00, no done; SEG_ACTIVE_LOW=1 instance given inverted "42" (4C,12) -> binary=2A.
